// File: rtl/cgra_conf_loader_pkg.sv
// CGRA configuration loader: shared constants, FSM state type and
// slot address helper used by the loader, its counter and interface.
package cgra_conf_loader_pkg;

   localparam int CONF_STRIDE       = 4;
   localparam int CONF_SIZE         = 80;
   localparam int WORST_MEM_LATENCY = 4;

   // Byte offset of each bitstream slot, one CONF_SIZE block per slot.
   localparam logic [3:0][31:0] CONF_OFFSET = {
      32'h0000_00F0,
      32'h0000_00A0,
      32'h0000_0050,
      32'h0000_0000
   };

   localparam int CONF_WORDS      = CONF_SIZE / CONF_STRIDE;
   localparam int MAX_OUTSTANDING = WORST_MEM_LATENCY;
   localparam int CNT_W           = $clog2(CONF_WORDS + 1);
   localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      S_CONF_IDLE,
      S_CONF_FETCH,
      S_CONF_DRAIN,
      S_CONF_DONE
   } conf_fsm_t;

   // First word address of a slot; 32-bit modulo arithmetic.
   function automatic logic [31:0] conf_slot_addr(
      input logic [31:0] base,
      input logic [1:0]  slot
   );
      return base + CONF_OFFSET[slot];
   endfunction

endpackage

// File: rtl/cgra_conf_loader_if.sv
// OBI-style read port: req/addr/gnt request phase, in-order rvalid/rdata.
// master = requester (loader), slave = memory.
interface cgra_conf_loader_if;

   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req,
      output addr,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output gnt,
      output rvalid,
      output rdata
   );

endinterface

// File: rtl/cgra_outstanding_cnt.sv
// Up/down saturating counter of reads in flight with full/empty flags.
// Ports: clk_i, rst_i (sync, high), clr_i, inc_i, dec_i, cnt_o, full_o, empty_o.
module cgra_outstanding_cnt #(
   parameter int MAX = 4,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam logic [W-1:0] MAX_C = W'(MAX);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // inc and dec together cancel; saturate at both ends.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !dec_i && cnt_q != MAX_C) begin
         cnt_d = cnt_q + W'(1);
      end else if (dec_i && !inc_i && cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign full_o  = (cnt_q == MAX_C);
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/cgra_conf_loader.sv
// Fetches one CGRA config slot over an OBI read port and streams the
// words into the fabric config registers.
// Ports: clk_i, rst_i (sync, high), start_i, base_addr_i, slot_i,
//   busy_o, done_o, mem (read master), conf_we_o, conf_idx_o, conf_data_o.
module cgra_conf_loader
   import cgra_conf_loader_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [31:0]       base_addr_i,
   input  logic [1:0]        slot_i,
   output logic              busy_o,
   output logic              done_o,
   cgra_conf_loader_if.master mem,
   output logic              conf_we_o,
   output logic [CNT_W-1:0]  conf_idx_o,
   output logic [31:0]       conf_data_o
);

   localparam logic [CNT_W-1:0] WORDS_C  = CNT_W'(CONF_WORDS);
   localparam logic [31:0]      STRIDE_C = 32'(CONF_STRIDE);

   conf_fsm_t        state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] returned_q, returned_d;
   logic             conf_we_q, conf_we_d;
   logic [CNT_W-1:0] conf_idx_q, conf_idx_d;
   logic [31:0]      conf_data_q, conf_data_d;

   logic             loading;
   logic             req;
   logic             fire;
   logic             resp;
   logic             cnt_clr;
   logic             cnt_full;
   logic             cnt_empty;
   logic [OUT_W-1:0] outstanding;

   assign loading = (state_q == S_CONF_FETCH) ||
                    (state_q == S_CONF_DRAIN);

   // req depends only on registered state, so it stays high
   // with a stable address until gnt arrives.
   assign req  = (state_q == S_CONF_FETCH) && !cnt_full &&
                 (issued_q < WORDS_C);
   assign fire = req && mem.gnt;
   // Responses outside a load or with nothing in flight are stale.
   assign resp = loading && mem.rvalid && !cnt_empty;

   cgra_outstanding_cnt #(
      .MAX (MAX_OUTSTANDING),
      .W   (OUT_W)
   ) u_outstanding (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (cnt_clr),
      .inc_i   (fire),
      .dec_i   (resp),
      .cnt_o   (outstanding),
      .full_o  (cnt_full),
      .empty_o (cnt_empty)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      issued_d    = issued_q;
      returned_d  = returned_q;
      conf_we_d   = 1'b0;
      conf_idx_d  = conf_idx_q;
      conf_data_d = conf_data_q;
      cnt_clr     = 1'b0;

      unique case (state_q)
         S_CONF_IDLE: begin
            if (start_i) begin
               state_d    = S_CONF_FETCH;
               addr_d     = conf_slot_addr(base_addr_i, slot_i);
               issued_d   = '0;
               returned_d = '0;
               cnt_clr    = 1'b1;
            end
         end
         S_CONF_FETCH: begin
            if (fire) begin
               issued_d = issued_q + CNT_W'(1);
               addr_d   = addr_q + STRIDE_C;
               if (issued_q == WORDS_C - CNT_W'(1)) begin
                  state_d = S_CONF_DRAIN;
               end
            end
         end
         S_CONF_DRAIN: begin
            if (returned_q == WORDS_C) begin
               state_d = S_CONF_DONE;
            end
         end
         S_CONF_DONE: begin
            state_d = S_CONF_IDLE;
         end
         default: begin
            state_d = S_CONF_IDLE;
         end
      endcase

      if (resp) begin
         conf_we_d   = 1'b1;
         conf_idx_d  = returned_q;
         conf_data_d = mem.rdata;
         returned_d  = returned_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_CONF_IDLE;
         addr_q      <= '0;
         issued_q    <= '0;
         returned_q  <= '0;
         conf_we_q   <= 1'b0;
         conf_idx_q  <= '0;
         conf_data_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         issued_q    <= issued_d;
         returned_q  <= returned_d;
         conf_we_q   <= conf_we_d;
         conf_idx_q  <= conf_idx_d;
         conf_data_q <= conf_data_d;
      end
   end

   assign busy_o      = loading;
   assign done_o      = (state_q == S_CONF_DONE);
   assign mem.req     = req;
   assign mem.addr    = addr_q;
   assign conf_we_o   = conf_we_q;
   assign conf_idx_o  = conf_idx_q;
   assign conf_data_o = conf_data_q;

   a_no_orphan_rvalid : assert property (
      @(posedge clk_i) disable iff (rst_i)
      !(loading && mem.rvalid && cnt_empty));

   a_outstanding_max : assert property (
      @(posedge clk_i) disable iff (rst_i)
      outstanding <= OUT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_cgra_conf_loader.sv
// Bench for cgra_conf_loader: latency-programmable memory, reference
// model checked every cycle, plus directed literal checks per scenario.
module tb_cgra_conf_loader;
   import cgra_conf_loader_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [31:0]      base;
   logic [1:0]       slot;
   logic             busy;
   logic             done;
   logic             we;
   logic [CNT_W-1:0] idx;
   logic [31:0]      data;

   cgra_conf_loader_if mem();

   cgra_conf_loader dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .base_addr_i (base),
      .slot_i      (slot),
      .busy_o      (busy),
      .done_o      (done),
      .mem         (mem),
      .conf_we_o   (we),
      .conf_idx_o  (idx),
      .conf_data_o (data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] slot_off(input logic [1:0] s);
      logic [31:0] t [4];
      t = '{32'h0, 32'h50, 32'hA0, 32'hF0};
      return t[s];
   endfunction

   // Memory-side settings owned by the stimulus process.
   int  lat = 1;
   bit  stall_mode = 0;
   int  stall_base = 0;

   // Memory-side state owned by the driver process.
   int  cyc = 0;
   int  n_stalled = 0;

   // Observation state owned by the compare process.
   logic [31:0] q_addr[$];
   int          q_due[$];
   logic [31:0] gaddr[$];
   int          gcyc[$];
   int          rv_cyc[$];
   int          done_cycs[$];
   int          start_cycs[$];
   int          n_grant = 0;
   int          n_we = 0;
   int          max_q = 0;
   logic [31:0] last_data19 = '0;

   int tests_c = 0, fails_c = 0;
   int tests_s = 0, fails_s = 0;

   task automatic chk_c(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      tests_c++;
      if (act !== exp) begin
         fails_c++;
         $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_s(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      tests_s++;
      if (act !== exp) begin
         fails_s++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Memory driver: in-order responses lat cycles after the grant cycle.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
         mem.rvalid = 1'b1;
         mem.rdata  = mem_word(q_addr[0]);
      end else begin
         mem.rvalid = 1'b0;
         mem.rdata  = 32'h0BAD_0BAD;
      end
      if (stall_mode && (n_grant - stall_base) == 3 &&
          n_stalled < 5 && mem.req) begin
         mem.gnt = 1'b0;
         n_stalled++;
      end else begin
         mem.gnt = 1'b1;
      end
   end

   // Reference model: phase 0 idle, 1 loading, 2 done.
   int          m_ph = 0, m_iss = 0, m_ret = 0, m_inf = 0;
   logic [31:0] m_addr = '0, m_base = '0, m_data = '0;
   int          m_idx = 0;
   bit          m_we = 0;
   bit          m_req;
   bit          m_fire, m_acc;

   always @(negedge clk) begin
      m_req = (m_ph == 1) && (m_iss < CONF_WORDS) &&
              (m_inf < MAX_OUTSTANDING);
      chk_c("busy", 32'(busy), 32'(m_ph == 1));
      chk_c("done", 32'(done), 32'(m_ph == 2));
      chk_c("req", 32'(mem.req), 32'(m_req));
      chk_c("addr", mem.addr, m_addr);
      chk_c("we", 32'(we), 32'(m_we));
      chk_c("idx", 32'(idx), 32'(m_idx));
      chk_c("data", data, m_data);
      if (stall_mode && mem.req && !mem.gnt)
         chk_c("stall_addr", mem.addr, 32'h0000_100C);

      if (mem.req && mem.gnt) begin
         q_addr.push_back(mem.addr);
         q_due.push_back(cyc + lat);
         gaddr.push_back(mem.addr);
         gcyc.push_back(cyc);
         n_grant++;
         if (q_due.size() > max_q) max_q = q_due.size();
      end
      if (mem.rvalid) begin
         rv_cyc.push_back(cyc);
         void'(q_due.pop_front());
         void'(q_addr.pop_front());
      end
      if (we) begin
         n_we++;
         if (idx == CNT_W'(19)) last_data19 = data;
      end
      if (done) done_cycs.push_back(cyc);

      m_fire = m_req && mem.gnt;
      m_acc  = (m_ph == 1) && mem.rvalid && (m_inf > 0);
      if (rst) begin
         m_ph = 0; m_iss = 0; m_ret = 0; m_inf = 0;
         m_addr = '0; m_we = 0; m_idx = 0; m_data = '0;
      end else begin
         m_we = m_acc;
         if (m_acc) begin
            m_idx  = m_ret;
            m_data = mem_word(m_base + 32'(m_ret) * 32'd4);
         end
         case (m_ph)
            0: if (start) begin
               m_ph = 1; m_iss = 0; m_ret = 0; m_inf = 0;
               m_base = base + slot_off(slot);
               m_addr = m_base;
               start_cycs.push_back(cyc);
            end
            1: begin
               if (m_ret == CONF_WORDS) m_ph = 2;
               if (m_fire) begin
                  m_iss++;
                  m_addr = m_addr + 32'd4;
               end
               m_ret = m_ret + int'(m_acc);
               m_inf = m_inf + int'(m_fire) - int'(m_acc);
            end
            default: m_ph = 0;
         endcase
      end
   end

   task automatic run_load(input logic [31:0] b, input logic [1:0] s);
      @(posedge clk); #2;
      start = 1'b1; base = b; slot = s;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int d0);
      int k;
      k = 0;
      while (done_cycs.size() <= d0 && k < 400) begin
         @(posedge clk); k++;
      end
      if (done_cycs.size() <= d0) begin
         tests_s++; fails_s++;
         $display("FAIL %s: no done_o within bound", nm);
      end
      repeat (2) @(posedge clk);
   endtask

   int s0, d0, w0, g0, r0, w1, r1, k;

   initial begin
      rst = 1'b1; start = 1'b0; base = '0; slot = '0;
      repeat (2) @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      chk_s("rst_busy", 32'(busy), 32'h0);
      chk_s("rst_req", 32'(mem.req), 32'h0);
      chk_s("rst_we", 32'(we), 32'h0);

      // Single-cycle memory, base 0x1000 slot 2.
      lat = 1;
      s0 = start_cycs.size(); d0 = done_cycs.size();
      w0 = n_we; g0 = gaddr.size();
      run_load(32'h0000_1000, 2'd2);
      wait_done("t1", d0);
      chk_s("t1_first_addr", gaddr[g0], 32'h0000_10A0);
      chk_s("t1_last_addr", gaddr[g0 + 19], 32'h0000_10EC);
      chk_s("t1_reads", 32'(gaddr.size() - g0), 32'd20);
      chk_s("t1_writes", 32'(n_we - w0), 32'd20);
      chk_s("t1_done_cyc", 32'(done_cycs[d0] - start_cycs[s0]), 32'd23);
      chk_s("t1_word19", last_data19, 32'hDEAD_AE03);

      // gnt withheld five cycles on request 3.
      stall_base = n_grant; stall_mode = 1;
      d0 = done_cycs.size(); w0 = n_we;
      run_load(32'h0000_1000, 2'd0);
      wait_done("t2", d0);
      stall_mode = 0;
      chk_s("t2_stalls", 32'(n_stalled), 32'd5);
      chk_s("t2_writes", 32'(n_we - w0), 32'd20);

      // Six-cycle read latency.
      lat = 6;
      s0 = start_cycs.size(); d0 = done_cycs.size();
      g0 = gcyc.size(); r0 = rv_cyc.size(); w0 = n_we;
      run_load(32'h0000_4000, 2'd1);
      wait_done("t3", d0);
      chk_s("t3_max_inflight", 32'(max_q), 32'd4);
      chk_s("t3_first_rv", 32'(rv_cyc[r0] - start_cycs[s0]), 32'd7);
      chk_s("t3_fifth_gnt", 32'(gcyc[g0 + 4] - start_cycs[s0]), 32'd8);
      chk_s("t3_writes", 32'(n_we - w0), 32'd20);

      // start pulsed mid-load and in the DONE cycle.
      lat = 1;
      s0 = start_cycs.size(); d0 = done_cycs.size(); w0 = n_we;
      run_load(32'h0000_2000, 2'd3);
      repeat (9) @(posedge clk); #2;
      start = 1'b1; base = 32'h0000_9000;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (12) @(posedge clk); #2;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (10) @(posedge clk);
      chk_s("t4_dones", 32'(done_cycs.size() - d0), 32'd1);
      chk_s("t4_starts", 32'(start_cycs.size() - s0), 32'd1);
      chk_s("t4_done_cyc", 32'(done_cycs[d0] - start_cycs[s0]), 32'd23);
      chk_s("t4_writes", 32'(n_we - w0), 32'd20);

      // Reset after seven writes, then a clean reload.
      lat = 4;
      w0 = n_we;
      run_load(32'h0000_3000, 2'd1);
      k = 0;
      while (n_we < w0 + 7 && k < 200) begin
         @(negedge clk); k++;
      end
      chk_s("t5_seven_writes", 32'(n_we - w0 >= 7), 32'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      w1 = n_we; r1 = rv_cyc.size();
      chk_s("t5_busy0", 32'(busy), 32'h0);
      chk_s("t5_done0", 32'(done), 32'h0);
      chk_s("t5_req0", 32'(mem.req), 32'h0);
      chk_s("t5_addr0", mem.addr, 32'h0);
      chk_s("t5_we0", 32'(we), 32'h0);
      chk_s("t5_idx0", 32'(idx), 32'h0);
      chk_s("t5_data0", data, 32'h0);
      k = 0;
      while (q_due.size() > 0 && k < 50) begin
         @(posedge clk); k++;
      end
      repeat (3) @(posedge clk);
      chk_s("t5_late_rv_seen", 32'(rv_cyc.size() > r1), 32'd1);
      chk_s("t5_late_we", 32'(n_we - w1), 32'd0);
      lat = 1;
      d0 = done_cycs.size(); w0 = n_we;
      run_load(32'h0000_5000, 2'd0);
      wait_done("t5", d0);
      chk_s("t5_reload_writes", 32'(n_we - w0), 32'd20);

      // Address wrap-around.
      lat = 2;
      d0 = done_cycs.size(); w0 = n_we; g0 = gaddr.size();
      run_load(32'hFFFF_FFF0, 2'd0);
      wait_done("t6", d0);
      chk_s("t6_word3", gaddr[g0 + 3], 32'hFFFF_FFFC);
      chk_s("t6_word4", gaddr[g0 + 4], 32'h0000_0000);
      chk_s("t6_last", gaddr[g0 + 19], 32'h0000_003C);
      chk_s("t6_writes", 32'(n_we - w0), 32'd20);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed",
               tests_c + tests_s, fails_c + fails_s);
      $finish;
   end

endmodule
